// File: rtl/threshold_monitor_pkg.sv
// Shared definitions for the threshold monitor: FSM state encoding and a
// ceiling-log2 helper used to size the debounce counter.
package threshold_monitor_pkg;

    localparam logic [1:0] BELOW   = 2'd0;
    localparam logic [1:0] PEND_UP = 2'd1;
    localparam logic [1:0] ABOVE   = 2'd2;
    localparam logic [1:0] PEND_DN = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/threshold_monitor.sv
// Debounced threshold comparator with hysteresis, edge pulses and a
// saturating count of rising crossings.
//
// state   | meaning
// BELOW   | idle below threshold, waiting for first sample > thresh
// PEND_UP | counting consecutive valid samples > thresh
// ABOVE   | asserted, waiting for first sample < lower
// PEND_DN | counting consecutive valid samples < lower (above still 1)
module threshold_monitor
    import threshold_monitor_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int DEBOUNCE = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] thresh,
    input  logic [WIDTH-1:0] hyst,
    input  logic             clr_cnt,
    output logic             above,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] cross_cnt
);

    localparam int DB_W = (clog2(DEBOUNCE + 1) < 1) ? 1 : clog2(DEBOUNCE + 1);

    logic [1:0]       state, state_nxt;
    logic [DB_W-1:0]  db_cnt, db_nxt;
    logic [WIDTH-1:0] lower;
    logic             enter_q, exit_q, db_last;
    logic             rise_evt, fall_evt;

    // lower clamps at zero, which makes the exit condition unreachable
    assign lower   = (thresh > hyst) ? (thresh - hyst) : '0;
    assign enter_q = sample_valid && (sample > thresh);
    assign exit_q  = sample_valid && (sample < lower);
    assign db_last = ((int'(db_cnt) + 1) == DEBOUNCE);

    always_comb begin
        state_nxt = state;
        db_nxt    = db_cnt;
        case (state)
            BELOW: begin
                if (enter_q) begin
                    if (DEBOUNCE == 1) begin
                        state_nxt = ABOVE;
                    end else begin
                        state_nxt = PEND_UP;
                        db_nxt    = DB_W'(1);
                    end
                end
            end
            PEND_UP: begin
                if (enter_q) begin
                    if (db_last) begin
                        state_nxt = ABOVE;
                        db_nxt    = '0;
                    end else begin
                        db_nxt = db_cnt + DB_W'(1);
                    end
                end else if (sample_valid) begin
                    state_nxt = BELOW;
                    db_nxt    = '0;
                end
            end
            ABOVE: begin
                if (exit_q) begin
                    if (DEBOUNCE == 1) begin
                        state_nxt = BELOW;
                    end else begin
                        state_nxt = PEND_DN;
                        db_nxt    = DB_W'(1);
                    end
                end
            end
            PEND_DN: begin
                if (exit_q) begin
                    if (db_last) begin
                        state_nxt = BELOW;
                        db_nxt    = '0;
                    end else begin
                        db_nxt = db_cnt + DB_W'(1);
                    end
                end else if (sample_valid) begin
                    state_nxt = ABOVE;
                    db_nxt    = '0;
                end
            end
            default: begin
                state_nxt = BELOW;
                db_nxt    = '0;
            end
        endcase
    end

    // state bit 1 is set exactly in ABOVE and PEND_DN
    assign above    = state[1];
    assign rise_evt = ~state[1] & state_nxt[1];
    assign fall_evt = state[1] & ~state_nxt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BELOW;
            db_cnt     <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            db_cnt     <= db_nxt;
            rise_pulse <= rise_evt;
            fall_pulse <= fall_evt;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cross_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (rise_evt),
        .clr  (clr_cnt),
        .q    (cross_cnt)
    );

endmodule

// File: tb/tb_threshold_monitor.sv
// Scoreboard bench for threshold_monitor: three instances (debounce 1/2/3)
// driven by directed vectors with hand-computed expected outputs.
module tb_threshold_monitor;

    logic       clk;
    logic       rst_n;
    logic       rst3_n;
    logic       valid   [3];
    logic [6:0] smp     [3];
    logic [6:0] th      [3];
    logic [6:0] hy      [3];
    logic       clr     [3];
    logic       above_o [3];
    logic       rise_o  [3];
    logic       fall_o  [3];
    logic [1:0] cnt_a;
    logic [7:0] cnt_b;
    logic [7:0] cnt_c;

    typedef struct {
        int    id;
        logic  above;
        logic  rise;
        logic  fall;
        int    cnt;
        string name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    threshold_monitor #(.WIDTH(7), .DEBOUNCE(1), .CNT_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .sample_valid(valid[0]), .sample(smp[0]),
        .thresh(th[0]), .hyst(hy[0]), .clr_cnt(clr[0]), .above(above_o[0]),
        .rise_pulse(rise_o[0]), .fall_pulse(fall_o[0]), .cross_cnt(cnt_a)
    );

    threshold_monitor #(.WIDTH(7), .DEBOUNCE(2), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .sample_valid(valid[1]), .sample(smp[1]),
        .thresh(th[1]), .hyst(hy[1]), .clr_cnt(clr[1]), .above(above_o[1]),
        .rise_pulse(rise_o[1]), .fall_pulse(fall_o[1]), .cross_cnt(cnt_b)
    );

    threshold_monitor #(.WIDTH(7), .DEBOUNCE(3), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst3_n), .sample_valid(valid[2]), .sample(smp[2]),
        .thresh(th[2]), .hyst(hy[2]), .clr_cnt(clr[2]), .above(above_o[2]),
        .rise_pulse(rise_o[2]), .fall_pulse(fall_o[2]), .cross_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: one expected record per stimulus cycle, compared after the edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic a, r, f;
            int   c;
            cur = exp_q.pop_front();
            case (cur.id)
                0:       begin a = above_o[0]; r = rise_o[0]; f = fall_o[0]; c = int'(cnt_a); end
                1:       begin a = above_o[1]; r = rise_o[1]; f = fall_o[1]; c = int'(cnt_b); end
                default: begin a = above_o[2]; r = rise_o[2]; f = fall_o[2]; c = int'(cnt_c); end
            endcase
            n_checks++;
            if (a !== cur.above || r !== cur.rise || f !== cur.fall || c != cur.cnt) begin
                n_fail++;
                $display("FAIL %s (dut %0d): got above=%b rise=%b fall=%b cnt=%0d, want above=%b rise=%b fall=%b cnt=%0d",
                         cur.name, cur.id, a, r, f, c, cur.above, cur.rise, cur.fall, cur.cnt);
            end
        end
    end

    task automatic step(input int id, input logic v, input int s, input int t, input int h,
                        input logic c, input logic ea, input logic er, input logic ef,
                        input int ecnt, input string nm);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            clr[i]   = 1'b0;
        end
        valid[id] = v;
        smp[id]   = 7'(s);
        th[id]    = 7'(t);
        hy[id]    = 7'(h);
        clr[id]   = c;
        e.id = id; e.above = ea; e.rise = er; e.fall = ef; e.cnt = ecnt; e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        int k;
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0; smp[i] = '0; th[i] = 7'd63; hy[i] = '0; clr[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        rst3_n = 1'b1;

        // reset state of each instance
        step(0, 0, 0, 63, 0, 0, 0, 0, 0, 0, "reset_a");
        step(1, 0, 0, 63, 0, 0, 0, 0, 0, 0, "reset_b");
        step(2, 0, 0, 63, 0, 0, 0, 0, 0, 0, "reset_c");

        // sweep 0..99, debounce 1: rises on 64
        for (int s = 0; s < 100; s++)
            step(0, 1, s, 63, 0, 0, s > 63, s == 64, 0, (s >= 64) ? 1 : 0, "sweep");

        // hysteresis: lower = 59, falls on 58, 59 itself holds
        for (int s = 70; s >= 50; s--)
            step(0, 1, s, 63, 4, 0, s >= 59, 0, s == 58, 1, "hyst_down");
        for (int s = 51; s <= 70; s++)
            step(0, 1, s, 63, 4, 0, s >= 64, s == 64, 0, (s >= 64) ? 2 : 1, "hyst_up");

        // saturation of 2-bit counter and clear priority
        step(0, 0, 0, 63, 4, 1, 1, 0, 0, 0, "clr_only");
        for (k = 1; k <= 5; k++) begin
            step(0, 1, 0,   63, 4, 0, 0, 0, 1, (k - 1 > 3) ? 3 : k - 1, "sat_fall");
            step(0, 1, 100, 63, 4, 0, 1, 1, 0, (k > 3) ? 3 : k, "sat_rise");
        end
        step(0, 1, 0,   63, 4, 0, 0, 0, 1, 3, "sat_fall6");
        step(0, 1, 100, 63, 4, 1, 1, 1, 0, 0, "clr_with_rise");
        step(0, 0, 0,   63, 4, 0, 1, 0, 0, 0, "after_clr_idle");

        // edge values
        step(0, 1, 0,   63,  4, 0, 0, 0, 1, 0, "edge_exit");
        step(0, 1, 0,   127, 0, 0, 0, 0, 0, 0, "thr127_0");
        step(0, 1, 64,  127, 0, 0, 0, 0, 0, 0, "thr127_64");
        step(0, 1, 126, 127, 0, 0, 0, 0, 0, 0, "thr127_126");
        step(0, 1, 127, 127, 0, 0, 0, 0, 0, 0, "thr127_127");
        step(0, 1, 6,   5, 10, 0, 1, 1, 0, 1, "lower0_enter");
        step(0, 1, 0,   5, 10, 0, 1, 0, 0, 1, "lower0_hold0");
        step(0, 1, 0,   5, 10, 0, 1, 0, 0, 1, "lower0_hold1");
        step(0, 1, 3,   5, 10, 0, 1, 0, 0, 1, "lower0_hold2");

        // debounce 2
        step(1, 1, 10, 63, 0, 0, 0, 0, 0, 0, "db_10");
        step(1, 1, 70, 63, 0, 0, 0, 0, 0, 0, "db_70_single");
        step(1, 1, 10, 63, 0, 0, 0, 0, 0, 0, "db_10_abort");
        step(1, 1, 70, 63, 0, 0, 0, 0, 0, 0, "db_70");
        step(1, 1, 71, 63, 0, 0, 1, 1, 0, 1, "db_71_rise");
        step(1, 1, 0,  63, 0, 0, 1, 0, 0, 1, "db_pend_dn");
        step(1, 1, 70, 63, 0, 0, 1, 0, 0, 1, "db_dn_abort");
        step(1, 1, 0,  63, 0, 0, 1, 0, 0, 1, "db_pend_dn2");
        step(1, 1, 0,  63, 0, 0, 0, 0, 1, 1, "db_fall");
        step(1, 1, 70, 63, 0, 0, 0, 0, 0, 1, "gap_pend");
        step(1, 0, 90, 63, 0, 0, 0, 0, 0, 1, "gap_no_adv0");
        step(1, 0, 90, 63, 0, 0, 0, 0, 0, 1, "gap_no_adv1");
        step(1, 1, 10, 63, 0, 0, 0, 0, 0, 1, "gap_abort");
        step(1, 1, 10, 63, 0, 0, 0, 0, 0, 1, "gap_seq_10");
        step(1, 1, 70, 63, 0, 0, 0, 0, 0, 1, "gap_seq_70");
        step(1, 0, 10, 63, 0, 0, 0, 0, 0, 1, "gap_hold");
        step(1, 1, 71, 63, 0, 0, 1, 1, 0, 2, "gap_seq_71_rise");

        // debounce 3 and reset while pending
        step(2, 1, 80, 63, 0, 0, 0, 0, 0, 0, "d3_80a");
        step(2, 1, 80, 63, 0, 0, 0, 0, 0, 0, "d3_80b");
        step(2, 1, 80, 63, 0, 0, 1, 1, 0, 1, "d3_80c_rise");
        step(2, 1, 0,  63, 0, 0, 1, 0, 0, 1, "d3_0a");
        step(2, 1, 0,  63, 0, 0, 1, 0, 0, 1, "d3_0b");
        step(2, 1, 0,  63, 0, 0, 0, 0, 1, 1, "d3_0c_fall");
        step(2, 1, 80, 63, 0, 0, 0, 0, 0, 1, "d3_pend1");
        step(2, 1, 80, 63, 0, 0, 0, 0, 0, 1, "d3_pend2");
        @(posedge clk);
        #3;
        for (int i = 0; i < 3; i++) valid[i] = 1'b0;
        rst3_n = 1'b0;
        #1;
        n_checks++;
        if (above_o[2] !== 1'b0 || rise_o[2] !== 1'b0 || fall_o[2] !== 1'b0 || cnt_c !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: got above=%b rise=%b fall=%b cnt=%0d, want all 0",
                     above_o[2], rise_o[2], fall_o[2], cnt_c);
        end
        @(negedge clk);
        rst3_n = 1'b1;
        step(2, 0, 0,  63, 0, 0, 0, 0, 0, 0, "post_rst_idle");
        step(2, 1, 80, 63, 0, 0, 0, 0, 0, 0, "post_rst_80a");
        step(2, 1, 80, 63, 0, 0, 0, 0, 0, 0, "post_rst_80b");
        step(2, 1, 80, 63, 0, 0, 1, 1, 0, 1, "post_rst_80c_rise");

        @(negedge clk);
        for (int i = 0; i < 3; i++) valid[i] = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/threshold_monitor.md
Name: threshold_monitor

Overview:
- Parametrised successor to the fixed "greater than 63" comparator.
- Monitors a stream of unsigned samples against a run-time threshold, with programmable hysteresis and a consecutive-sample debounce.
- Produces a registered `above` flag, single-cycle edge pulses and a saturating count of qualified crossings.
- Sits after the digit/combination counters in the lab datapath and drives the display/alarm logic.

Parameters:
WIDTH, 7, sample/threshold width in bits (unsigned)
DEBOUNCE, 2, consecutive valid qualifying samples required to change state (>=1; 1 = immediate)
CNT_W, 8, width of crossing counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sample_valid  in  1  sample is evaluated on this cycle
sample  in  WIDTH  unsigned sample
thresh  in  WIDTH  upper threshold; entry condition is sample > thresh
hyst  in  WIDTH  hysteresis; exit condition is sample < (thresh - hyst)
clr_cnt  in  1  synchronous clear of cross_cnt
above  out  1  registered debounced state
rise_pulse  out  1  one-cycle pulse when above goes 0->1
fall_pulse  out  1  one-cycle pulse when above goes 1->0
cross_cnt  out  CNT_W  number of rising transitions, saturating

Behaviour:
- Reset (async, rst_n=0): state=BELOW, db_cnt=0, above=0, rise_pulse=0, fall_pulse=0, cross_cnt=0.
- Arithmetic:
  - lower = (thresh > hyst) ? thresh - hyst : 0, computed at WIDTH bits.
  - All compares are unsigned.
  - When lower=0, the exit condition never holds, so above stays set until reset.
- Qualifying sample:
  - In BELOW/PEND_UP: sample_valid & (sample > thresh).
  - In ABOVE/PEND_DN: sample_valid & (sample < lower).
- FSM states BELOW, PEND_UP, ABOVE, PEND_DN; db_cnt counts qualifying samples.
  - BELOW: qualifying sample with DEBOUNCE=1 -> ABOVE; otherwise -> PEND_UP with db_cnt=1.
  - PEND_UP:
    - Qualifying sample and db_cnt+1==DEBOUNCE -> ABOVE, db_cnt=0.
    - Qualifying sample otherwise -> db_cnt+1.
    - Valid non-qualifying sample -> BELOW, db_cnt=0.
  - ABOVE / PEND_DN: mirror of BELOW / PEND_UP using the exit condition; PEND_DN aborts back to ABOVE.
  - sample_valid=0: hold state and db_cnt. Gaps neither advance nor break the debounce.
- Outputs:
  - above=1 exactly in ABOVE and PEND_DN. Registered; updates on the edge that captures the DEBOUNCE-th qualifying sample, with zero added latency beyond that edge.
  - rise_pulse/fall_pulse are high for the single cycle following the transition edge; never both high.
  - cross_cnt increments on each BELOW/PEND_UP->ABOVE transition and saturates at 2^CNT_W-1.
  - clr_cnt has priority over increment; the result is 0 that cycle and the pulse is still emitted.
- Run-time inputs: thresh/hyst are sampled combinationally with each valid sample. A change takes effect on the next valid sample and does not reset a pending debounce.
- Reset mid-PEND: the pending count is discarded and all outputs return to reset values immediately.
- Boundaries:
  - sample == thresh does not qualify for entry.
  - sample == lower does not qualify for exit.
  - thresh = 2^WIDTH-1 makes entry impossible.

Decomposition:
- Shared package `threshold_monitor_pkg`: state encoding constants (BELOW=2'd0, PEND_UP=2'd1, ABOVE=2'd2, PEND_DN=2'd3) and a clog2 function for the db_cnt width.
- One natural sub-module, `sat_counter` (CNT_W, inc, clr, q), instantiated for cross_cnt.
- FSM, compare and lower computation stay in the top module.

Test Plan:
- Sweep: WIDTH=7, DEBOUNCE=1, thresh=63, hyst=0; sample 0..99 one per cycle, valid=1.
  - above rises on the edge capturing 64; rise_pulse for one cycle; cross_cnt=1.
  - Values 0..63 keep above=0.
- Hysteresis: thresh=63, hyst=4, DEBOUNCE=1; ramp 70 down to 50.
  - above stays 1 through 59 and falls on the edge capturing 58; fall_pulse one cycle.
  - Re-ramp up: re-entry at 64.
- Debounce: DEBOUNCE=2; samples 10,70,10,70,71 -> single 70 gives no change; above rises on the edge capturing 71.
  - Same sequence with valid=0 inserted between 70 and 71 -> still rises at 71.
- Saturation/clear: CNT_W=2; generate 5 crossings -> cross_cnt 1,2,3,3,3.
  - clr_cnt pulse coincident with a 6th crossing -> cross_cnt=0 and rise_pulse=1.
- Reset mid-pending: DEBOUNCE=3; apply two samples of 80, assert rst_n=0 asynchronously mid-cycle.
  - All outputs 0 immediately.
  - After release, a third 80 alone does not set above; three more do.
- Edge values: thresh=127 -> above never sets for any input.
  - thresh=5, hyst=10 -> after entering, sample 0 never clears above.
